// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg
//   Shared types and constants for the run monitor.
//   state_t           : controller state encoding (RUN/DRAIN/DUMP/DONE)
//   HALT_INST_DEFAULT : default halt-detect instruction encoding (ebreak)
package run_monitor_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DUMP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] HALT_INST_DEFAULT = 32'h0010_0073;

    localparam int DRAIN_CNT_W = 8;

endpackage

// File: rtl/run_monitor_dump_seq.sv
// run_monitor_dump_seq
//   Word-index sequencer for the memory dump. While active, presents the
//   byte address of the current word and advances on each accepted handshake.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     active     : controller is in DUMP
//     ready      : consumer accepts the current address
//     valid      : address is valid (mirrors active)
//     addr       : byte address, 4 * word index
//     last       : the final word is being accepted this cycle
module run_monitor_dump_seq #(
    parameter int DUMP_WORDS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        active,
    input  logic        ready,
    output logic        valid,
    output logic [31:0] addr,
    output logic        last
);

    localparam int IDX_W = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DUMP_WORDS - 1);

    logic [IDX_W-1:0] idx;
    logic             accept;

    assign valid  = active;
    assign accept = active && ready;
    assign last   = accept && (idx == LAST_IDX);
    assign addr   = 32'(idx) << 2;

    // The index parks on the final word; the controller leaves DUMP on that
    // acceptance, so it never needs to wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
        end else if (accept && (idx != LAST_IDX)) begin
            idx <= idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/run_monitor.sv
// run_monitor
//   Watches instruction fetch on NUM_HARTS channels, counts run cycles, and
//   ends the run when every hart has fetched HALT_INST (then drains for
//   DRAIN_CYCLES) or when TIMEOUT_CYCLES elapse. Afterwards it sequences
//   DUMP_WORDS data-memory word addresses out over a valid/ready handshake.
//   Optional feature macro: RUN_MONITOR_INSTRET_EN adds per-hart retired
//   fetch counters on output instret.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     inst_valid  : per-hart fetch strobe
//     inst        : per-hart fetched instruction, hart h at [32h+31:32h]
//     dump_ready  : consumer accepts dump_addr
//     state       : RUN=0, DRAIN=1, DUMP=2, DONE=3
//     cycles      : saturating cycle count, frozen from DUMP onward
//     timeout     : sticky, run ended by cycle limit
//     done        : sticky, dump complete
//     dump_valid  : dump_addr valid
//     dump_addr   : byte address of the word being dumped
//     instret     : (macro only) per-hart fetch counts, CNT_W bits per hart
//
//   state | meaning
//   RUN   | counting cycles, collecting per-hart halts, watching the limit
//   DRAIN | all harts halted, waiting DRAIN_CYCLES for the pipeline to empty
//   DUMP  | sequencing dump addresses, cycle count frozen
//   DONE  | dump finished, terminal until reset
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int          NUM_HARTS      = 1,
    parameter logic [31:0] HALT_INST      = HALT_INST_DEFAULT,
    parameter int          DRAIN_CYCLES   = 5,
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter int          DUMP_WORDS     = 20,
    parameter int          CNT_W          = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_HARTS-1:0]       inst_valid,
    input  logic [32*NUM_HARTS-1:0]    inst,
    input  logic                       dump_ready,
    output logic [1:0]                 state,
    output logic [CNT_W-1:0]           cycles,
    output logic                       timeout,
    output logic                       done,
    output logic                       dump_valid,
`ifdef RUN_MONITOR_INSTRET_EN
    output logic [CNT_W*NUM_HARTS-1:0] instret,
`endif
    output logic [31:0]                dump_addr
);

    localparam int DRAIN_LOAD_I = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_LOAD_I);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [NUM_HARTS-1:0]   halt_seen;
    logic [NUM_HARTS-1:0]   halt_hit;
    logic [DRAIN_CNT_W-1:0] drain_cnt;
    logic [CNT_W-1:0]       cycles_q;
    logic                   timeout_q;
    logic                   done_q;
    logic                   all_halt;
    logic                   limit_hit;
    logic                   counting;
    logic                   dump_last;

    always_comb begin
        halt_hit = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            halt_hit[h] = inst_valid[h] && (inst[32*h +: 32] == HALT_INST);
        end
    end

    // Halts arriving this very cycle count toward completion.
    assign all_halt  = &(halt_seen | halt_hit);
    assign limit_hit = (cycles_q == TIMEOUT_LAST);
    assign counting  = (state_q == RUN) || (state_q == DRAIN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                // Halt completion takes priority over a coincident timeout.
                if (all_halt) begin
                    state_d = (DRAIN_CYCLES == 0) ? DUMP : DRAIN;
                end else if (limit_hit) begin
                    state_d = DUMP;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_d = DUMP;
                end
            end
            DUMP: begin
                if (dump_last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            halt_seen <= '0;
            drain_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (counting && (cycles_q != '1)) begin
                cycles_q <= cycles_q + CNT_W'(1);
            end
            if (state_q == RUN) begin
                halt_seen <= halt_seen | halt_hit;
            end
            // Terminal-count down-counter: loaded with N-1 so DRAIN spans N cycles.
            if ((state_q == RUN) && (state_d == DRAIN)) begin
                drain_cnt <= DRAIN_LOAD;
            end else if ((state_q == DRAIN) && (drain_cnt != '0)) begin
                drain_cnt <= drain_cnt - DRAIN_CNT_W'(1);
            end
            if ((state_q == RUN) && !all_halt && limit_hit) begin
                timeout_q <= 1'b1;
            end
            if ((state_q == DUMP) && dump_last) begin
                done_q <= 1'b1;
            end
        end
    end

    run_monitor_dump_seq #(
        .DUMP_WORDS (DUMP_WORDS)
    ) u_dump_seq (
        .clk    (clk),
        .reset  (reset),
        .active (state_q == DUMP),
        .ready  (dump_ready),
        .valid  (dump_valid),
        .addr   (dump_addr),
        .last   (dump_last)
    );

`ifdef RUN_MONITOR_INSTRET_EN
    logic [NUM_HARTS-1:0][CNT_W-1:0] instret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= '0;
        end else if (counting) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (inst_valid[h] && (instret_q[h] != '1)) begin
                    instret_q[h] <= instret_q[h] + CNT_W'(1);
                end
            end
        end
    end

    assign instret = instret_q;
`endif

    assign state   = state_q;
    assign cycles  = cycles_q;
    assign timeout = timeout_q;
    assign done    = done_q;

endmodule

// File: tb/tb_run_monitor.sv
`timescale 1ns/1ps
// tb_run_monitor
//   Directed scoreboard bench. Stimulus pushes expected dump-entry records and
//   dump addresses; a negedge monitor pops and compares as the DUT presents
//   them. A second instance covers the zero-drain, single-word configuration.
//   Optional feature macro: RUN_MONITOR_INSTRET_EN enables instret checks.
module tb_run_monitor;
    import run_monitor_pkg::*;

    localparam logic [31:0] HALT = 32'h0010_0073;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  inst_valid;
    logic [63:0] inst;
    logic        dump_ready;
    logic [1:0]  state;
    logic [31:0] cycles;
    logic        timeout, done, dump_valid;
    logic [31:0] dump_addr;

    logic [0:0]  v1;
    logic [31:0] i1;
    logic        r1;
    logic [1:0]  state1;
    logic [31:0] cycles1;
    logic        timeout1, done1, dv1;
    logic [31:0] addr1;

`ifdef RUN_MONITOR_INSTRET_EN
    logic [63:0] instret;
    logic [31:0] instret1;
`endif

    run_monitor #(
        .NUM_HARTS(2), .DRAIN_CYCLES(5), .TIMEOUT_CYCLES(200), .DUMP_WORDS(4)
    ) u0 (
        .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst(inst),
        .dump_ready(dump_ready), .state(state), .cycles(cycles),
        .timeout(timeout), .done(done), .dump_valid(dump_valid),
`ifdef RUN_MONITOR_INSTRET_EN
        .instret(instret),
`endif
        .dump_addr(dump_addr)
    );

    run_monitor #(
        .DRAIN_CYCLES(0), .DUMP_WORDS(1)
    ) u1 (
        .clk(clk), .reset(reset), .inst_valid(v1), .inst(i1),
        .dump_ready(r1), .state(state1), .cycles(cycles1),
        .timeout(timeout1), .done(done1), .dump_valid(dv1),
`ifdef RUN_MONITOR_INSTRET_EN
        .instret(instret1),
`endif
        .dump_addr(addr1)
    );

    typedef struct {
        logic [31:0] cyc;
        logic        tmo;
        int          drain;
    } entry_t;

    entry_t      entry_q[$];
    logic [31:0] addr_q[$];
    entry_t      e;
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares dump entry, every presented dump address, and the
    // completion that must follow the last accepted word.
    logic [1:0] prev_state = 2'd0;
    int         drain_len = 0;
    bit         expect_done = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            prev_state  = RUN;
            drain_len   = 0;
            expect_done = 1'b0;
        end else begin
            if (expect_done) begin
                chk("done_after_last", done, 1);
                chk("valid_after_last", dump_valid, 0);
                chk("state_after_last", state, DONE);
                expect_done = 1'b0;
            end
            if (state == DRAIN) drain_len++;
            if ((state == DUMP) && (prev_state != DUMP)) begin
                if (entry_q.size() == 0) begin
                    fail_now("dump_entry");
                end else begin
                    e = entry_q.pop_front();
                    chk("entry_cycles", cycles, e.cyc);
                    chk("entry_timeout", timeout, e.tmo);
                    chk("drain_len", drain_len, e.drain);
                end
                drain_len = 0;
            end
            if (dump_valid) begin
                if (addr_q.size() == 0) begin
                    fail_now("dump_addr");
                end else begin
                    chk("dump_addr", dump_addr, addr_q[0]);
                    if (dump_ready) begin
                        void'(addr_q.pop_front());
                        if (addr_q.size() == 0) expect_done = 1'b1;
                    end
                end
            end
            prev_state = state;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        inst_valid = '0; inst = '0; dump_ready = 1'b0;
        v1 = '0; i1 = '0; r1 = 1'b0;
        repeat (3) step();
        chk("rst_state", state, RUN);
        chk("rst_cycles", cycles, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", dump_valid, 0);
        chk("rst_addr", dump_addr, 0);
        reset = 1'b0;
    endtask

    task automatic push_addrs(input int n);
        for (int i = 0; i < n; i++) addr_q.push_back(32'(4 * i));
    endtask

    task automatic wait_done(input int max_cyc, input bit toggle);
        int n;
        n = 0;
        while (!done && (n < max_cyc)) begin
            step();
            if (toggle) dump_ready = ~dump_ready;
            n++;
        end
        if (!done) fail_now("wait_done_timeout");
        step();
        chk("entry_q_drained", entry_q.size(), 0);
        chk("addr_q_drained", addr_q.size(), 0);
    endtask

    initial begin
        // Halt on both harts at cycles=100, dump with toggling ready;
        // second instance halts at cycles=10 with no drain.
        do_reset();
        entry_q.push_back('{cyc: 32'd106, tmo: 1'b0, drain: 5});
        push_addrs(4);
        repeat (10) step();
        v1 = 1'b1; i1 = HALT; r1 = 1'b1;
        step();
        v1 = 1'b0;
        chk("nd_state_dump", state1, DUMP);
        chk("nd_cycles", cycles1, 11);
        chk("nd_valid", dv1, 1);
        chk("nd_addr", addr1, 0);
        chk("nd_timeout", timeout1, 0);
        step();
        chk("nd_done", done1, 1);
        chk("nd_state_done", state1, DONE);
        chk("nd_valid_done", dv1, 0);
        v1 = 1'b1;
        repeat (58) step();
        inst_valid = 2'b01; inst = {NOP, NOP};
        repeat (30) step();
        inst_valid = 2'b11; inst = {HALT, HALT};
        step();
        inst_valid = 2'b00; inst = '0;
        dump_ready = 1'b1;
        wait_done(60, 1'b1);
        inst_valid = 2'b11; inst = {HALT, NOP};
        repeat (5) step();
        chk("done_frozen_cycles", cycles, 106);
        chk("done_terminal", state, DONE);
        chk("nd_frozen_cycles", cycles1, 11);
        chk("nd_terminal", state1, DONE);
`ifdef RUN_MONITOR_INSTRET_EN
        chk("instret_h0", instret[31:0], 31);
        chk("instret_h1", instret[63:32], 1);
`endif

        // Staggered halts; a halt encoding without valid must be ignored.
        do_reset();
        entry_q.push_back('{cyc: 32'd86, tmo: 1'b0, drain: 5});
        push_addrs(4);
        dump_ready = 1'b1;
        repeat (50) step();
        inst_valid = 2'b01; inst = {NOP, HALT};
        step();
        inst_valid = 2'b00; inst = '0;
        repeat (9) step();
        inst = {HALT, NOP};
        step();
        inst = '0;
        repeat (9) step();
        chk("stagger_still_run", state, RUN);
        repeat (10) step();
        inst_valid = 2'b10; inst = {HALT, NOP};
        step();
        inst_valid = 2'b00; inst = '0;
        chk("stagger_drain", state, DRAIN);
        wait_done(40, 1'b0);

        // No halt: timeout ends the run at cycles=200, skipping DRAIN.
        do_reset();
        entry_q.push_back('{cyc: 32'd200, tmo: 1'b1, drain: 0});
        push_addrs(4);
        dump_ready = 1'b1;
        wait_done(260, 1'b0);
        chk("timeout_sticky", timeout, 1);

        // Halt coincident with the limit: halt wins, full drain, then reset
        // while the sequencer sits on word 2.
        do_reset();
        entry_q.push_back('{cyc: 32'd205, tmo: 1'b0, drain: 5});
        push_addrs(3);
        dump_ready = 1'b1;
        repeat (199) step();
        inst_valid = 2'b11; inst = {HALT, HALT};
        step();
        inst_valid = 2'b00; inst = '0;
        chk("coinc_drain", state, DRAIN);
        chk("coinc_timeout", timeout, 0);
        repeat (7) step();
        dump_ready = 1'b0;
        step();
        chk("mid_state", state, DUMP);
        chk("mid_addr", dump_addr, 8);
        chk("mid_pending", addr_q.size(), 1);
        addr_q.delete();
        reset = 1'b1;
        step();
        chk("mid_rst_state", state, RUN);
        chk("mid_rst_cycles", cycles, 0);
        chk("mid_rst_valid", dump_valid, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_addr", dump_addr, 0);
        reset = 1'b0;
        step();
        chk("first_count", cycles, 1);
        chk("restart_state", state, RUN);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
